sc_global_pose_integrator: RTL

Periodic pose integrator that sits directly downstream of the global-velocity sequencer. It issues the one-cycle `ready` request that starts each global-velocity computation. When the sequencer pulses `done`, it samples the rotated global velocities (vx, vy) and the yaw rate, and integrates them into a registered pose (x, y, theta). The pose feeds the navigation/odometry layer.

---
 rtl/sc_global_pose_integrator_pkg.sv | 17 +
 rtl/sc_pose_accumulator.sv | 27 ++
 rtl/sc_global_pose_integrator.sv | 106 ++++++++++
 3 files changed

// File: rtl/sc_global_pose_integrator_pkg.sv
// rtl/sc_global_pose_integrator_pkg.sv - FSM states and widths shared by the pose integrator
package sc_global_pose_integrator_pkg;

  localparam int VEL_W = 16;
  localparam int POS_W = 32;
  localparam int TH_W  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DONE = 3'd2,
    LATCH     = 3'd3,
    ACCUM     = 3'd4,
    PUBLISH   = 3'd5
  } pose_state_t;

endpackage

// File: rtl/sc_pose_accumulator.sv
// rtl/sc_pose_accumulator.sv - 32-bit signed position add; clamps on overflow when POSE_SATURATION_EN is defined
module sc_pose_accumulator
  import sc_global_pose_integrator_pkg::*;
(
  input  logic signed [POS_W-1:0] acc,
  input  logic signed [POS_W:0]   delta,
  output logic signed [POS_W-1:0] sum
);

`ifdef POSE_SATURATION_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic signed [POS_W:0] wide;

  assign wide = {acc[POS_W-1], acc} + delta;

  // Top two bits disagree only when the 33-bit sum left the 32-bit range.
  always_comb begin
    sum = wide[POS_W-1:0];
    if (SAT && (wide[POS_W] != wide[POS_W-1]))
      sum = wide[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
  end

endmodule

// File: rtl/sc_global_pose_integrator.sv
// rtl/sc_global_pose_integrator.sv - periodic pose integrator behind the global-velocity sequencer
// POSE_SATURATION_EN selects clamping instead of wrapping for x and y.
module sc_global_pose_integrator
  import sc_global_pose_integrator_pkg::*;
#(
  parameter int PERIOD   = 50000,
  parameter int DT_SHIFT = 10
) (
  input  logic                    SC_STATEMACHINE_GLOBAL_VEL_CLOCK_50,
  input  logic                    SC_STATEMACHINE_GLOBAL_VEL_RESET_InHigh,
  input  logic                    done_InHigh,
  input  logic signed [VEL_W-1:0] vel_x_In,
  input  logic signed [VEL_W-1:0] vel_y_In,
  input  logic signed [VEL_W-1:0] omega_In,
  input  logic                    clear_InHigh,
  output logic                    ready_Out,
  output logic signed [POS_W-1:0] pose_x_Out,
  output logic signed [POS_W-1:0] pose_y_Out,
  output logic [TH_W-1:0]         pose_theta_Out,
  output logic                    pose_valid_Out,
  output logic                    overrun_Out
);

  localparam int CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0]        timer;
  logic                    tick;
  pose_state_t             state;
  logic signed [VEL_W-1:0] vx_q, vy_q, om_q;
  logic signed [POS_W:0]   dx, dy;
  logic signed [POS_W-1:0] x_next, y_next;
  logic [TH_W-1:0]         dth;

  assign tick = (timer == CNT_W'(PERIOD - 1));
  assign dx   = $signed((POS_W+1)'(vx_q)) >>> DT_SHIFT;
  assign dy   = $signed((POS_W+1)'(vy_q)) >>> DT_SHIFT;
  assign dth  = om_q >>> DT_SHIFT;

  sc_pose_accumulator u_acc_x (.acc(pose_x_Out), .delta(dx), .sum(x_next));
  sc_pose_accumulator u_acc_y (.acc(pose_y_Out), .delta(dy), .sum(y_next));

  always_ff @(posedge SC_STATEMACHINE_GLOBAL_VEL_CLOCK_50 or posedge SC_STATEMACHINE_GLOBAL_VEL_RESET_InHigh) begin
    if (SC_STATEMACHINE_GLOBAL_VEL_RESET_InHigh)
      timer <= '0;
    else if (tick)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  always_ff @(posedge SC_STATEMACHINE_GLOBAL_VEL_CLOCK_50 or posedge SC_STATEMACHINE_GLOBAL_VEL_RESET_InHigh) begin
    if (SC_STATEMACHINE_GLOBAL_VEL_RESET_InHigh) begin
      state          <= IDLE;
      ready_Out      <= 1'b0;
      pose_valid_Out <= 1'b0;
      overrun_Out    <= 1'b0;
      pose_x_Out     <= '0;
      pose_y_Out     <= '0;
      pose_theta_Out <= '0;
      vx_q           <= '0;
      vy_q           <= '0;
      om_q           <= '0;
    end else begin
      ready_Out      <= 1'b0;
      pose_valid_Out <= 1'b0;

      if (clear_InHigh)
        overrun_Out <= 1'b0;
      else if (tick && (state != IDLE))
        overrun_Out <= 1'b1;

      if (clear_InHigh) begin
        pose_x_Out     <= '0;
        pose_y_Out     <= '0;
        pose_theta_Out <= '0;
      end else if (state == ACCUM) begin
        pose_x_Out     <= x_next;
        pose_y_Out     <= y_next;
        pose_theta_Out <= pose_theta_Out + dth;
      end

      case (state)
        IDLE: if (tick) begin
          state     <= REQ;
          ready_Out <= 1'b1;
        end
        REQ: state <= WAIT_DONE;
        // Samples are only valid alongside done, so they are captured on the edge entering LATCH.
        WAIT_DONE: if (done_InHigh) begin
          vx_q  <= vel_x_In;
          vy_q  <= vel_y_In;
          om_q  <= omega_In;
          state <= LATCH;
        end
        LATCH: state <= ACCUM;
        ACCUM: begin
          state          <= PUBLISH;
          pose_valid_Out <= 1'b1;
        end
        PUBLISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
